dmem_access_ctrl: RTL and testbench

Sequencer and two-port round-robin arbiter in front of the byte-addressable 64-bit data memory. Port 0 is the core load/store path; port 1 is the program-loader/debug path. Converts sized RISC-V accesses (B/H/W/D, signed/unsigned) into whole-doubleword memory cycles. Sub-doubleword stores use read-modify-write. Loads are sign- or zero-extended.

---
 rtl/dmem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: two-port round-robin sequencer turning sized RISC-V loads/stores into 64-bit memory cycles
module dmem_access_ctrl #(
  parameter int MEM_BYTES   = 1024,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic        p0_err,
  output logic [63:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic        p1_err,
  output logic [63:0] p1_rdata,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, DONE} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, port_q, port_d, uns_q, uns_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [63:0] addr_q, addr_d, buf_q, buf_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic g0, g1, s_we, s_uns, s_err;
  logic [1:0] s_size;
  logic [63:0] s_addr, s_wdata, ld_val, merged;
  assign g0 = rst_n && state_q == IDLE && p0_req && (!p1_req || last_q);
  assign g1 = rst_n && state_q == IDLE && p1_req && (!p0_req || !last_q);
  assign s_we = g1 ? p1_we : p0_we;
  assign s_size = g1 ? p1_size : p0_size;
  assign s_uns = g1 ? p1_unsigned : p0_unsigned;
  assign s_addr = g1 ? p1_addr : p0_addr;
  assign s_wdata = g1 ? p1_wdata : p0_wdata;
  assign s_err = ({1'b0, s_addr} > 65'(MEM_BYTES - 8)) ||
                 (ALIGN_CHECK != 0 && (s_addr[2:0] & ((3'd1 << s_size) - 3'd1)) != 3'd0);
  assign ld_val = size_q == 2'd0 ? {{56{!uns_q && mem_read_data[7]}}, mem_read_data[7:0]} :
                  size_q == 2'd1 ? {{48{!uns_q && mem_read_data[15]}}, mem_read_data[15:0]} :
                  size_q == 2'd2 ? {{32{!uns_q && mem_read_data[31]}}, mem_read_data[31:0]} :
                  mem_read_data;
  assign merged = size_q == 2'd0 ? {mem_read_data[63:8], buf_q[7:0]} :
                  size_q == 2'd1 ? {mem_read_data[63:16], buf_q[15:0]} :
                  size_q == 2'd2 ? {mem_read_data[63:32], buf_q[31:0]} :
                  buf_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    port_d = port_q;
    uns_d = uns_q;
    err_d = err_q;
    size_d = size_q;
    addr_d = addr_q;
    buf_d = buf_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (g0 || g1) begin
      state_d = s_err ? DONE : !s_we ? LOAD : s_size == 2'd3 ? STORE : RMW_RD;
      last_d = g1;
      port_d = g1;
      uns_d = s_uns;
      err_d = s_err;
      size_d = s_size;
      addr_d = s_addr;
      buf_d = s_wdata;
    end else begin
      state_d = (state_q == LOAD || state_q == STORE) ? DONE :
                state_q == RMW_RD ? STORE :
                state_q == DONE ? IDLE : state_q;
    end
    if (state_q == RMW_RD) buf_d = merged;
    if (state_q == LOAD && !port_q) rdata0_d = ld_val;
    if (state_q == LOAD && port_q) rdata1_d = ld_val;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      port_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      buf_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      port_q <= port_d;
      uns_q <= uns_d;
      err_q <= err_d;
      size_q <= size_d;
      addr_q <= addr_d;
      buf_q <= buf_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign p0_gnt = g0;
  assign p1_gnt = g1;
  assign p0_done = state_q == DONE && !port_q;
  assign p1_done = state_q == DONE && port_q;
  assign p0_err = p0_done && err_q;
  assign p1_err = p1_done && err_q;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;
  assign mem_read = state_q == LOAD || state_q == RMW_RD;
  assign mem_write = state_q == STORE;
  assign mem_address = (mem_read || mem_write) ? addr_q : '0;
  assign mem_write_data = mem_write ? buf_q : '0;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized and directed checks of dmem_access_ctrl against a byte-level memory model
module tb_dmem_access_ctrl;
  localparam int MEM_BYTES = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic p0_req = 0, p0_we = 0, p0_unsigned = 0, p1_req = 0, p1_we = 0, p1_unsigned = 0;
  logic [1:0] p0_size = 0, p1_size = 0;
  logic [63:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, mem_read, mem_write;
  logic [63:0] p0_rdata, p1_rdata, mem_address, mem_write_data, mem_read_data;
  logic [7:0] mem [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic [63:0] exp_rd [0:1];
  int n_checks = 0;
  int n_pass = 0;

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_read_data = '0;
    if (mem_address <= 64'(MEM_BYTES - 8))
      for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = mem[int'(mem_address) + i];
  end

  always @(posedge clk)
    if (mem_write && mem_address <= 64'(MEM_BYTES - 8))
      for (int i = 0; i < 8; i++) mem[int'(mem_address) + i] <= mem_write_data[8*i +: 8];

  function automatic bit ref_err(input logic [63:0] a, input logic [1:0] sz);
    return (a > 64'(MEM_BYTES - 8)) || ((a % (64'd1 << sz)) != 0);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input bit uns);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic drive(input int p, input bit rq, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_size = sz; p0_unsigned = uns; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = rq; p1_we = we; p1_size = sz; p1_unsigned = uns; p1_addr = a; p1_wdata = wd;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic access(input int p, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd,
                        output int lat, output bit err, output logic [63:0] rd,
                        output int nrd, output int nwr, output int bad, output int gw);
    bit g = 0;
    lat = -1; err = 0; rd = '0; nrd = 0; nwr = 0; bad = 0; gw = -1;
    @(negedge clk);
    drive(p, 1, we, sz, uns, a, wd);
    for (int t = 0; t < 50 && !g; t++) begin
      #1;
      g = (p == 1) ? p1_gnt : p0_gnt;
      if (g) begin
        gw = t;
        if ((p == 1) ? p0_gnt : p1_gnt) bad++;
      end else @(negedge clk);
    end
    if (!g) begin
      drive(p, 0, 0, 0, 0, 0, 0);
      return;
    end
    @(posedge clk);
    #1;
    drive(p, 0, 1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (mem_read && mem_write) bad++;
      if ((p == 1) ? (p0_done || p0_err) : (p1_done || p1_err)) bad++;
      if ((p == 1) ? p1_done : p0_done) begin
        lat = c;
        err = (p == 1) ? p1_err : p0_err;
        rd = (p == 1) ? p1_rdata : p0_rdata;
      end
    end
    if (!ref_err(a, sz)) begin
      if (we) for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      else exp_rd[p] = ref_load(a, sz, uns);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    drive(0, 1, 0, 3, 0, 0, 0);
    drive(1, 1, 0, 3, 0, 8, 0);
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b00) $display("FAIL reset_gnt got %b exp 00", {p0_gnt, p1_gnt}); else n_pass++;
    n_checks++; if ({p0_done, p0_err, p1_done, p1_err} !== 4'b0) $display("FAIL reset_done_err got %b exp 0000", {p0_done, p0_err, p1_done, p1_err}); else n_pass++;
    n_checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_mem_rw got %b exp 00", {mem_read, mem_write}); else n_pass++;
    n_checks++; if (mem_address !== 64'd0 || mem_write_data !== 64'd0) $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_address, mem_write_data); else n_pass++;
    n_checks++; if (p0_rdata !== 64'd0 || p1_rdata !== 64'd0) $display("FAIL reset_rdata got %h/%h exp 0/0", p0_rdata, p1_rdata); else n_pass++;
    reset_dut();
  endtask

  task automatic test_basic();
    int lat, nrd, nwr, bad, gw; bit err; logic [63:0] rd;
    access(0, 1, 3, 0, 64'd16, 64'h8877665544332211, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (lat !== 2 || err !== 1'b0) $display("FAIL sd_lat got %0d err %b exp 2 err 0", lat, err); else n_pass++;
    n_checks++; if (nrd !== 0 || nwr !== 1) $display("FAIL sd_cycles got rd %0d wr %0d exp rd 0 wr 1", nrd, nwr); else n_pass++;
    access(0, 0, 0, 0, 64'd23, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (lat !== 2) $display("FAIL lb_lat got %0d exp 2", lat); else n_pass++;
    n_checks++; if (rd !== 64'hFFFFFFFFFFFFFF88) $display("FAIL lb_data got %h exp ffffffffffffff88", rd); else n_pass++;
    access(0, 0, 0, 1, 64'd23, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (rd !== 64'h88) $display("FAIL lbu_data got %h exp 88", rd); else n_pass++;
  endtask

  task automatic test_rmw();
    int lat, nrd, nwr, bad, gw; bit err; logic [63:0] rd;
    access(1, 1, 0, 0, 64'd16, 64'h123456789ABCDEAA, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (lat !== 3 || err !== 1'b0) $display("FAIL sb_lat got %0d err %b exp 3 err 0", lat, err); else n_pass++;
    n_checks++; if (nrd !== 1 || nwr !== 1 || bad !== 0) $display("FAIL sb_cycles got rd %0d wr %0d bad %0d exp 1 1 0", nrd, nwr, bad); else n_pass++;
    access(1, 0, 3, 0, 64'd16, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (rd !== 64'h88776655443322AA) $display("FAIL ld_after_sb got %h exp 88776655443322aa", rd); else n_pass++;
  endtask

  task automatic test_errors();
    int lat, nrd, nwr, bad, gw; bit err; logic [63:0] rd;
    access(0, 0, 3, 0, 64'd1017, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (err !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0) $display("FAIL err_bounds got err %b lat %0d rd %0d wr %0d exp 1 1 0 0", err, lat, nrd, nwr); else n_pass++;
    access(0, 0, 2, 0, 64'd2, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (err !== 1'b1 || lat !== 1) $display("FAIL err_align got err %b lat %0d exp 1 1", err, lat); else n_pass++;
    access(0, 0, 3, 0, 64'hFFFFFFFFFFFFFFF8, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (err !== 1'b1 || nrd !== 0) $display("FAIL err_wrap got err %b rd %0d exp 1 0", err, nrd); else n_pass++;
    access(1, 1, 0, 0, 64'd1023, 64'h55, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (err !== 1'b1 || nwr !== 0) $display("FAIL err_byte_top got err %b wr %0d exp 1 0", err, nwr); else n_pass++;
    access(1, 1, 3, 0, 64'd1016, 64'h0123456789ABCDEF, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (err !== 1'b0 || lat !== 2) $display("FAIL top_dword_ok got err %b lat %0d exp 0 2", err, lat); else n_pass++;
  endtask

  task automatic test_arb();
    int lat, nrd, nwr, bad, gw, both; bit err; logic [63:0] rd;
    int order[$];
    reset_dut();
    access(1, 0, 3, 0, 64'd8, 64'd0, lat, err, rd, nrd, nwr, bad, gw);
    n_checks++; if (gw !== 0 || bad !== 0) $display("FAIL lone_p1 got wait %0d bad %0d exp 0 0", gw, bad); else n_pass++;
    reset_dut();
    both = 0;
    @(negedge clk);
    drive(0, 1, 0, 3, 0, 64'd0, 0);
    drive(1, 1, 0, 3, 0, 64'd8, 0);
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      #1;
      if (p0_gnt && p1_gnt) both++;
      if (p0_gnt) order.push_back(0);
      if (p1_gnt) order.push_back(1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++; if (order.size() !== 4 || both !== 0) $display("FAIL b2b_count got %0d grants %0d double exp 4 0", order.size(), both); else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] !== i % 2) $display("FAIL b2b_order[%0d] got p%0d exp p%0d", i, order[i], i % 2); else n_pass++;
    end
    exp_rd[0] = ref_load(64'd0, 3, 0);
    exp_rd[1] = ref_load(64'd8, 3, 0);
    n_checks++; if (p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) $display("FAIL b2b_rdata got %h/%h exp %h/%h", p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      int p = int'($urandom_range(0, 1));
      bit we = 1'($urandom);
      logic [1:0] sz = 2'($urandom);
      bit uns = 1'($urandom);
      int r = int'($urandom_range(0, 9));
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] a, exp_v;
      int lat, nrd, nwr, bad, gw, exp_lat, exp_nrd, exp_nwr; bit err, exp_e; logic [63:0] rd;
      a = r == 0 ? 64'($urandom_range(1009, 1100)) :
          r == 1 ? {$urandom, $urandom} :
          r == 2 ? 64'($urandom_range(0, 120)) :
          64'($urandom_range(0, 120)) & ~((64'd1 << sz) - 64'd1);
      exp_e = ref_err(a, sz);
      exp_v = exp_e ? 64'd0 : we ? exp_rd[p] : ref_load(a, sz, uns);
      exp_lat = exp_e ? 1 : (!we || sz == 2'd3) ? 2 : 3;
      exp_nrd = (!exp_e && (!we || sz != 2'd3)) ? 1 : 0;
      exp_nwr = (!exp_e && we) ? 1 : 0;
      access(p, we, sz, uns, a, wd, lat, err, rd, nrd, nwr, bad, gw);
      n_checks++; if (err !== exp_e || lat !== exp_lat) $display("FAIL rnd%0d_err_lat p%0d we%0b sz%0d a=%h got err %b lat %0d exp %b %0d", k, p, we, sz, a, err, lat, exp_e, exp_lat); else n_pass++;
      n_checks++; if (nrd !== exp_nrd || nwr !== exp_nwr || bad !== 0) $display("FAIL rnd%0d_cycles got rd %0d wr %0d bad %0d exp %0d %0d 0", k, nrd, nwr, bad, exp_nrd, exp_nwr); else n_pass++;
      if (!exp_e) begin
        n_checks++; if (rd !== exp_v) $display("FAIL rnd%0d_rdata p%0d we%0b sz%0d u%0b a=%h got %h exp %h", k, p, we, sz, uns, a, rd, exp_v); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] old_w;
    bit dn = 0;
    reset_dut();
    old_w = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
    @(negedge clk);
    drive(0, 1, 1, 2, 0, 64'd32, {32'd0, ~old_w});
    #1;
    n_checks++; if (p0_gnt !== 1'b1) $display("FAIL rst_sw_gnt got %b exp 1", p0_gnt); else n_pass++;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 6 && !mem_write; c++) @(negedge clk);
    n_checks++; if (mem_write !== 1'b1) $display("FAIL rst_sw_store_reached got %b exp 1", mem_write); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) $display("FAIL rst_sw_mem_drop got wr %b rd %b exp 0 0", mem_write, mem_read); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      dn = dn | p0_done | p1_done;
    end
    n_checks++; if (dn !== 1'b0) $display("FAIL rst_sw_no_done got %b exp 0", dn); else n_pass++;
    n_checks++; if ({mem[35], mem[34], mem[33], mem[32]} !== old_w) $display("FAIL rst_sw_mem got %h exp %h", {mem[35], mem[34], mem[33], mem[32]}, old_w); else n_pass++;
    rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clk);
    drive(0, 1, 0, 3, 0, 64'd0, 0);
    drive(1, 1, 0, 3, 0, 64'd8, 0);
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) $display("FAIL rst_favour_p0 got %b exp 10", {p0_gnt, p1_gnt}); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      logic [7:0] b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    test_reset();
    test_basic();
    test_rmw();
    test_errors();
    test_arb();
    test_random();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
